sync_bus_arbiter: RTL and testbench

SYNC_BUS_ARBITER -- requirements
Module: sync_bus_arbiter

---
 rtl/sync_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_sync_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_bus_arbiter.sv
// Two-requester arbiter driving a registered bus into a four-phase
// bus_enable/ack handshake with a destination clock domain.
module sync_bus_arbiter #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_STAGE = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [BUS_WIDTH-1:0] data0,
  input  logic                 req1,
  input  logic [BUS_WIDTH-1:0] data1,
  input  logic                 ack,
  input  logic                 err_clr,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 done0,
  output logic                 done1,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [1:0]           state_dbg
);

  // Handshake: a grant raises bus_enable with unsync_bus stable; the destination
  // raises ack, bus_enable falls, the destination drops ack, then done pulses.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REL = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [NUM_STAGE-1:0]  ack_sync_q;
  logic                  ack_s;
  logic [15:0]           cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  pick;
  logic [BUS_WIDTH-1:0]  bus_d;
  logic                  en_d, done0_d, done1_d, err_d;
  logic                  timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[NUM_STAGE-2:0], ack};
    end
  end

  assign ack_s       = ack_sync_q[NUM_STAGE-1];
  assign timeout_hit = (cnt_q == CNT_LAST);
  // On a tie the port not served last wins; a lone request always wins.
  assign pick        = (req0 && req1) ? ~last_grant_q : ~req0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    bus_d        = unsync_bus;
    en_d         = bus_enable;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = err_clr ? 1'b0 : timeout_err;
    case (state_q)
      IDLE: begin
        if (!ack_s && (req0 || req1)) begin
          grant_d = pick;
          bus_d   = pick ? data1 : data0;
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s) begin
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_REL;
        end else if (timeout_hit) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_REL: begin
        if (!ack_s) begin
          done0_d = ~grant_q;
          done1_d = grant_q;
          state_d = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      unsync_bus   <= '0;
      bus_enable   <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      unsync_bus   <= bus_d;
      bus_enable   <= en_d;
      done0        <= done0_d;
      done1        <= done1_d;
      timeout_err  <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sync_bus_arbiter.sv
// Bench for sync_bus_arbiter: delayed-ack destination model, expected
// {port, payload} queue popped at each done pulse, scenario tasks in sequence.
module tb_sync_bus_arbiter;

  localparam int W  = 8;
  localparam int NS = 2;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, err_clr = 1'b0;
  logic [W-1:0] data0 = '0, data1 = '0;
  logic         ack;
  logic [W-1:0] unsync_bus;
  logic         bus_enable, done0, done1, busy, timeout_err;
  logic [1:0]   state_dbg;

  logic         auto_ack = 1'b0, ack_man = 1'b0, ack_auto = 1'b0;
  int           dly = 0;
  int           checks = 0, failures = 0;
  logic [W:0]   exp_q[$];
  logic         tb_last = 1'b1;

  sync_bus_arbiter #(.BUS_WIDTH(W), .NUM_STAGE(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack(ack), .err_clr(err_clr), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .done0(done0), .done1(done1), .busy(busy), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  // clock / destination model: ack follows bus_enable three edges later
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!auto_ack) begin
      ack_auto <= 1'b0;
      dly      <= 0;
    end else if (bus_enable != ack_auto) begin
      if (dly == 2) begin
        ack_auto <= bus_enable;
        dly      <= 0;
      end else begin
        dly <= dly + 1;
      end
    end else begin
      dly <= 0;
    end
  end

  assign ack = auto_ack ? ack_auto : ack_man;

  // driver tasks
  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int which);
    which = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done0) begin which = 0; req0 = 1'b0; break; end
      if (done1) begin which = 1; req1 = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (unsync_bus !== '0) begin failures++; $display("FAIL reset_bus: got %h want 00", unsync_bus); end
    checks++; if (bus_enable !== 1'b0) begin failures++; $display("FAIL reset_en: got %b want 0", bus_enable); end
    checks++; if ({done0, done1} !== 2'b00) begin failures++; $display("FAIL reset_done: got %b want 00", {done0, done1}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", timeout_err); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    rst = 1'b0;
  endtask

  task automatic test_tie;
    int which;
    logic [W:0] e;
    apply_reset();
    auto_ack = 1'b1;
    for (int r = 0; r < 2; r++) begin
      data0 = 8'h11; data1 = 8'h22;
      req0 = 1'b1; req1 = 1'b1;
      exp_q.push_back({1'b0, 8'h11});
      exp_q.push_back({1'b1, 8'h22});
      for (int k = 0; k < 2; k++) begin
        wait_done(200, which);
        e = exp_q.pop_front();
        checks++;
        if (which < 0 || {which[0], unsync_bus} !== e) begin
          failures++;
          $display("FAIL tie_grant r%0d k%0d: got port %0d bus %h, want port %0d bus %h",
                   r, k, which, unsync_bus, e[W], e[W-1:0]);
        end
      end
    end
    tb_last = 1'b1;
  endtask

  task automatic test_random;
    int which, pat, n;
    logic [W-1:0] d0, d1;
    logic first;
    logic [W:0] e;
    for (int r = 0; r < 6; r++) begin
      pat = $urandom_range(1, 3);
      d0  = W'($urandom_range(0, 255));
      d1  = W'($urandom_range(0, 255));
      if (pat == 3) begin
        first = ~tb_last;
        exp_q.push_back({first, first ? d1 : d0});
        exp_q.push_back({~first, first ? d0 : d1});
        tb_last = ~first;
        n = 2;
      end else begin
        first = (pat == 2);
        exp_q.push_back({first, first ? d1 : d0});
        tb_last = first;
        n = 1;
      end
      data0 = d0; data1 = d1;
      req0 = pat[0]; req1 = pat[1];
      for (int k = 0; k < n; k++) begin
        wait_done(200, which);
        e = exp_q.pop_front();
        checks++;
        if (which < 0 || {which[0], unsync_bus} !== e) begin
          failures++;
          $display("FAIL random_grant r%0d k%0d: got port %0d bus %h, want port %0d bus %h",
                   r, k, which, unsync_bus, e[W], e[W-1:0]);
        end
      end
    end
  endtask

  task automatic test_single;
    logic held_bad = 1'b0, saw_d1 = 1'b0, got = 1'b0;
    logic [W:0] e;
    auto_ack = 1'b1;
    @(negedge clk);
    data0 = 8'hA5; req0 = 1'b1;
    exp_q.push_back({1'b0, 8'hA5});
    @(negedge clk);
    checks++; if (bus_enable !== 1'b1 || unsync_bus !== 8'hA5) begin
      failures++; $display("FAIL single_grant_latency: got en %b bus %h want en 1 bus a5", bus_enable, unsync_bus);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (unsync_bus !== 8'hA5) held_bad = 1'b1;
      if (done1) saw_d1 = 1'b1;
      if (done0) begin got = 1'b1; break; end
    end
    e = exp_q.pop_front();
    checks++; if (!got || {1'b0, unsync_bus} !== e) begin
      failures++; $display("FAIL single_done: got done0 %b bus %h want done0 1 bus %h", got, unsync_bus, e[W-1:0]);
    end
    checks++; if (held_bad || saw_d1) begin
      failures++; $display("FAIL single_hold: bus changed %b done1 seen %b, want 0 0", held_bad, saw_d1);
    end
    req0 = 1'b0; data0 = 8'h5A;
    @(negedge clk);
    checks++; if (done0 !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_done_width: got done0 %b busy %b want 0 0", done0, busy);
    end
    checks++; if (unsync_bus !== 8'hA5) begin
      failures++; $display("FAIL single_bus_after_done: got %h want a5", unsync_bus);
    end
    tb_last = 1'b0;
  endtask

  task automatic test_timeout;
    int hi = 1, which;
    logic saw_done = 1'b0, blocked_bad = 1'b0, found = 1'b0;
    logic [W:0] e;
    auto_ack = 1'b0; ack_man = 1'b0;
    @(negedge clk);
    data1 = 8'h3C; req1 = 1'b1;
    @(negedge clk);
    checks++; if (bus_enable !== 1'b1) begin failures++; $display("FAIL to_grant: got en %b want 1", bus_enable); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done0 || done1) saw_done = 1'b1;
      if (!bus_enable) break;
      hi++;
    end
    checks++; if (hi != TO) begin failures++; $display("FAIL to_en_cycles: got %0d want %0d", hi, TO); end
    checks++; if (timeout_err !== 1'b1 || state_dbg !== 2'd0) begin
      failures++; $display("FAIL to_flag: got err %b state %0d want 1 0", timeout_err, state_dbg);
    end
    @(negedge clk);
    checks++; if (bus_enable !== 1'b1 || unsync_bus !== 8'h3C) begin
      failures++; $display("FAIL to_regrant: got en %b bus %h want 1 3c", bus_enable, unsync_bus);
    end
    // ack stuck high: WAIT_REL times out, then IDLE must hold off
    ack_man = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done0 || done1) saw_done = 1'b1;
      if (state_dbg == 2'd0) break;
    end
    repeat (5) begin
      @(negedge clk);
      if (bus_enable || busy) blocked_bad = 1'b1;
    end
    checks++; if (blocked_bad || saw_done) begin
      failures++; $display("FAIL to_ack_high_block: granted %b done %b want 0 0", blocked_bad, saw_done);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL err_clr: got %b want 0", timeout_err); end
    ack_man = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_enable) begin found = 1'b1; break; end
    end
    checks++; if (!found || unsync_bus !== 8'h3C) begin
      failures++; $display("FAIL to_grant_after_ack_low: got en %b bus %h want 1 3c", found, unsync_bus);
    end
    repeat (TO - 1) @(negedge clk);
    err_clr = 1'b1;
    data0 = 8'h5A; req0 = 1'b1;
    auto_ack = 1'b1;
    exp_q.push_back({1'b1, 8'h3C});
    exp_q.push_back({1'b0, 8'h5A});
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b1 || bus_enable !== 1'b0) begin
      failures++; $display("FAIL to_vs_err_clr: got err %b en %b want 1 0", timeout_err, bus_enable);
    end
    // timeouts leave last_grant at port 0, so port 1 wins this tie
    for (int k = 0; k < 2; k++) begin
      wait_done(200, which);
      e = exp_q.pop_front();
      checks++;
      if (which < 0 || {which[0], unsync_bus} !== e) begin
        failures++;
        $display("FAIL to_tie_after k%0d: got port %0d bus %h, want port %0d bus %h",
                 k, which, unsync_bus, e[W], e[W-1:0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int which;
    logic found = 1'b0, bad = 1'b0;
    logic [W:0] e;
    auto_ack = 1'b1;
    @(negedge clk);
    data0 = 8'h77; req0 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (state_dbg == 2'd2) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL rm_reach_wait_rel: got %b want 1", found); end
    rst = 1'b1;
    #1;
    checks++; if ({unsync_bus, bus_enable, done0, done1, busy, timeout_err} !== '0) begin
      failures++; $display("FAIL rm_async_clear: got bus %h en %b done %b%b busy %b err %b want all 0",
                           unsync_bus, bus_enable, done0, done1, busy, timeout_err);
    end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL rm_state: got %0d want 0", state_dbg); end
    data0 = 8'h99;
    repeat (3) begin
      @(negedge clk);
      if (bus_enable || done0 || done1 || busy) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL rm_hold: activity under reset %b want 0", bad); end
    rst = 1'b0;
    exp_q.push_back({1'b0, 8'h99});
    wait_done(200, which);
    e = exp_q.pop_front();
    checks++;
    if (which < 0 || {which[0], unsync_bus} !== e) begin
      failures++;
      $display("FAIL rm_after_release: got port %0d bus %h, want port %0d bus %h",
               which, unsync_bus, e[W], e[W-1:0]);
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_random();
    test_single();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
